// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the round-robin memory arbiter
//
// Purpose: arbiter FSM state encoding, memory op encoding, default line/address
//          widths, statistics counter width and a saturating increment helper.
// Ports:   none (package).

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } mem_op_t;

  localparam int LINE_W = 128;
  localparam int ADDR_W = 28;
  localparam int STAT_W = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// rtl/mem_arbiter_rr_picker.sv - combinational round-robin requester picker
//
// Purpose: returns the first asserted request at or after ptr, wrapping
//          NUM_CH-1 -> 0.
// Ports:
//   req    in   NUM_CH   request vector
//   ptr    in   IDX_W    search start index
//   grant  out  IDX_W    chosen channel index (0 when valid is low)
//   valid  out  1        at least one request present

module rr_picker #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  grant,
  output logic              valid
);

  localparam logic [IDX_W:0] NUM_CH_W = (IDX_W+1)'(NUM_CH);

  // One extra bit so ptr+k never overflows before the modulo fold.
  logic [IDX_W:0] cand;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= NUM_CH_W) begin
        cand = cand - NUM_CH_W;
      end
      if (!valid && req[cand[IDX_W-1:0]]) begin
        valid = 1'b1;
        grant = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - round-robin merge of cache-miss ports onto one memory line port
//
// Purpose: NUM_CH cache channels share one slow memory. One transaction in
//          flight; IDLE samples requests and grants round-robin, BUSY waits for
//          mem_ready, RESP pulses ch_ready and advances the pointer. Read data
//          is registered and broadcast to all channels.
// Optional build macro: MEMARB_STATS_EN adds grant/conflict counters.
// Ports:
//   clk            in   1               rising-edge clock
//   proc_reset     in   1               synchronous active-high reset
//   ch_read        in   NUM_CH          per-channel read request (level)
//   ch_write       in   NUM_CH          per-channel write request (level, wins over read)
//   ch_addr        in   NUM_CH*ADDR_W   channel i at [i*ADDR_W +: ADDR_W]
//   ch_wdata       in   NUM_CH*LINE_W   channel i at [i*LINE_W +: LINE_W]
//   ch_rdata       out  LINE_W          registered read line
//   ch_ready       out  NUM_CH          one-cycle completion pulse
//   mem_read       out  1               memory read request (level)
//   mem_write      out  1               memory write request (level)
//   mem_addr       out  ADDR_W          memory line address
//   mem_wdata      out  LINE_W          memory write line
//   mem_rdata      in   LINE_W          memory read line, valid with mem_ready
//   mem_ready      in   1               memory completion pulse
//   stat_grants    out  NUM_CH*16       (MEMARB_STATS_EN) saturating per-channel grants
//   stat_conflicts out  16              (MEMARB_STATS_EN) saturating contended IDLE cycles

module mem_arbiter_rr #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = mem_arb_pkg::ADDR_W,
  parameter int LINE_W = mem_arb_pkg::LINE_W
) (
  input  logic                     clk,
  input  logic                     proc_reset,
  input  logic [NUM_CH-1:0]        ch_read,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
  output logic [LINE_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata,
  input  logic                     mem_ready
`ifdef MEMARB_STATS_EN
  ,
  output logic [NUM_CH*mem_arb_pkg::STAT_W-1:0] stat_grants,
  output logic [mem_arb_pkg::STAT_W-1:0]        stat_conflicts
`endif
);

  import mem_arb_pkg::*;

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  grant_q;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [NUM_CH-1:0] req;
  logic [ADDR_W-1:0] sel_addr;
  logic [LINE_W-1:0] sel_wdata;
  mem_op_t           sel_op;
  logic              grant_fire;
  logic              mem_done;

  assign req = ch_read | ch_write;

  rr_picker #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_picker (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_idx),
    .valid (pick_valid)
  );

  // Select the picked channel's address, data and op.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_op    = OP_RD;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        sel_addr  = ch_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = ch_wdata[i*LINE_W +: LINE_W];
        // A channel raising both read and write is served as a write only.
        sel_op    = ch_write[i] ? OP_WR : OP_RD;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    mem_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_fire = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          mem_done = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      ptr_q     <= '0;
      grant_q   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ch_rdata  <= '0;
      ch_ready  <= '0;
    end else begin
      ch_ready <= '0;
      if (grant_fire) begin
        grant_q   <= pick_idx;
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        mem_read  <= (sel_op == OP_RD);
        mem_write <= (sel_op == OP_WR);
      end
      if (mem_done) begin
        ch_rdata  <= mem_rdata;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          ch_ready[i] <= (grant_q == IDX_W'(i));
        end
      end
      // Pointer moves past the served channel only once it has been answered.
      if (state_q == RESP) begin
        ptr_q <= (grant_q == IDX_W'(NUM_CH-1)) ? '0 : grant_q + 1'b1;
      end
    end
  end

`ifdef MEMARB_STATS_EN
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      stat_grants    <= '0;
      stat_conflicts <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (grant_fire && pick_idx == IDX_W'(i)) begin
          stat_grants[i*STAT_W +: STAT_W] <= sat_inc(stat_grants[i*STAT_W +: STAT_W]);
        end
      end
      if (state_q == IDLE && $countones(req) > 1) begin
        stat_conflicts <= sat_inc(stat_conflicts);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - self-checking bench for mem_arbiter_rr

module tb_mem_arbiter_rr;

  localparam int N  = 2;
  localparam int AW = 28;
  localparam int LW = 128;

  logic            clk = 1'b0;
  logic            proc_reset = 1'b0;
  logic [N-1:0]    ch_read = '0;
  logic [N-1:0]    ch_write = '0;
  logic [N*AW-1:0] ch_addr = '0;
  logic [N*LW-1:0] ch_wdata = '0;
  logic [LW-1:0]   ch_rdata;
  logic [N-1:0]    ch_ready;
  logic            mem_read;
  logic            mem_write;
  logic [AW-1:0]   mem_addr;
  logic [LW-1:0]   mem_wdata;
  logic [LW-1:0]   mem_rdata = '0;
  logic            mem_ready = 1'b0;
`ifdef MEMARB_STATS_EN
  logic [N*16-1:0] stat_grants;
  logic [15:0]     stat_conflicts;
`endif

  mem_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .LINE_W(LW)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .ch_read    (ch_read),
    .ch_write   (ch_write),
    .ch_addr    (ch_addr),
    .ch_wdata   (ch_wdata),
    .ch_rdata   (ch_rdata),
    .ch_ready   (ch_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef MEMARB_STATS_EN
    ,
    .stat_grants    (stat_grants),
    .stat_conflicts (stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: one open transaction at a time, rotating priority.
  bit           m_open = 0;
  bit           m_resp = 0;
  int           m_ptr = 0;
  int           m_gnt = 0;
  logic         e_rd = 0;
  logic         e_wr = 0;
  logic [N-1:0] e_ready = '0;
  logic [AW-1:0] e_addr = '0;
  logic [LW-1:0] e_wdata = '0;
  logic [LW-1:0] e_rdata = '0;
  bit           chk_data = 0;
  bit           chk_rdata = 0;
  int           m_stat_g [N];
  int           m_stat_c = 0;

  // Agent controls.
  bit rand_en = 0, spur_en = 0, rand_lat = 0, rand_rst = 0, hold_mode = 0, fixed_data = 0;
  int mem_lat = 3;
  bit mem_pend = 0;
  int mem_cnt = 0;
  int obs_q [$];

  localparam logic [LW-1:0] A5_LINE = {16{8'hA5}};
  localparam logic [LW-1:0] T3_LINE = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;

  task automatic check(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_update();
    int nreq, g, c;
    chk_data  = 0;
    chk_rdata = 0;
    if (proc_reset) begin
      m_open = 0; m_resp = 0; m_ptr = 0; m_gnt = 0;
      e_rd = 0; e_wr = 0; e_ready = '0; e_addr = '0; e_wdata = '0; e_rdata = '0;
      for (int i = 0; i < N; i++) m_stat_g[i] = 0;
      m_stat_c  = 0;
      chk_data  = 1;
      chk_rdata = 1;
    end else if (m_resp) begin
      e_ready = '0;
      m_ptr   = (m_gnt + 1) % N;
      m_resp  = 0;
    end else if (m_open) begin
      chk_data = 1;
      if (mem_ready) begin
        e_rdata = mem_rdata;
        e_rd = 0; e_wr = 0;
        e_ready = '0;
        e_ready[m_gnt] = 1'b1;
        m_open = 0; m_resp = 1;
        chk_data = 0; chk_rdata = 1;
      end
    end else begin
      nreq = 0; g = -1;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (ch_read[c] || ch_write[c]) begin
          nreq++;
          if (g < 0) g = c;
        end
      end
      if (nreq > 1 && m_stat_c < 65535) m_stat_c++;
      if (g >= 0) begin
        m_gnt   = g;
        e_wr    = ch_write[g];
        e_rd    = ch_read[g] && !ch_write[g];
        e_addr  = ch_addr[g*AW +: AW];
        e_wdata = ch_wdata[g*LW +: LW];
        m_open  = 1;
        chk_data = 1;
        if (m_stat_g[g] < 65535) m_stat_g[g]++;
      end
    end
  endtask

  task automatic compare();
    check("mem_read", LW'(mem_read), LW'(e_rd));
    check("mem_write", LW'(mem_write), LW'(e_wr));
    check("ch_ready", LW'(ch_ready), LW'(e_ready));
    if (chk_data) begin
      check("mem_addr", LW'(mem_addr), LW'(e_addr));
      check("mem_wdata", mem_wdata, e_wdata);
    end
    if (chk_rdata) check("ch_rdata", ch_rdata, e_rdata);
`ifdef MEMARB_STATS_EN
    for (int i = 0; i < N; i++)
      check("stat_grants", LW'(stat_grants[i*16 +: 16]), LW'(m_stat_g[i]));
    check("stat_conflicts", LW'(stat_conflicts), LW'(m_stat_c));
`endif
    for (int i = 0; i < N; i++) if (ch_ready[i]) obs_q.push_back(i);
  endtask

  task automatic issue(input int i, input int kind);
    ch_read[i]  = (kind != 1);
    ch_write[i] = (kind != 0);
    ch_addr[i*AW +: AW]  = AW'($urandom);
    ch_wdata[i*LW +: LW] = rnd_line();
  endtask

  task automatic react();
    for (int i = 0; i < N; i++) begin
      if (ch_ready[i] && !hold_mode) begin
        ch_read[i] = 1'b0; ch_write[i] = 1'b0;
      end else if (rand_en && !ch_read[i] && !ch_write[i] && $urandom_range(0, 2) == 0) begin
        issue(i, int'($urandom_range(0, 2)));
      end
    end
    mem_ready = 1'b0;
    if (mem_read || mem_write) begin
      if (!mem_pend) begin
        mem_pend = 1;
        mem_cnt  = rand_lat ? int'($urandom_range(1, 6)) : mem_lat;
      end
      if (mem_cnt <= 1) begin
        mem_ready = 1'b1;
        mem_rdata = fixed_data ? A5_LINE : rnd_line();
        mem_pend  = 0;
      end else begin
        mem_cnt--;
      end
    end else begin
      mem_pend = 0;
      if (spur_en && $urandom_range(0, 7) == 0) begin
        mem_ready = 1'b1;
        mem_rdata = rnd_line();
      end
    end
    proc_reset = rand_rst && ($urandom_range(0, 399) == 0);
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    compare();
    react();
  endtask

  task automatic do_reset();
    ch_read = '0; ch_write = '0; mem_ready = 1'b0;
    proc_reset = 1'b1;
    step();
    proc_reset = 1'b0;
    obs_q.delete();
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (ch_ready == '0 && n < budget) begin
      step();
      n++;
    end
    check("wait_ready_timeout", LW'(ch_ready != '0), LW'(1));
  endtask

  task automatic wait_obs(input int count, input int budget);
    int n = 0;
    while (obs_q.size() < count && n < budget) begin
      step();
      n++;
    end
    check("wait_obs_timeout", LW'(obs_q.size() >= count), LW'(1));
  endtask

  task automatic run_until_quiet(input int budget);
    int n = 0;
    while ((ch_read != '0 || ch_write != '0 || m_open || m_resp) && n < budget) begin
      step();
      n++;
    end
    check("quiet_timeout", LW'(m_open || m_resp), LW'(0));
  endtask

  initial begin
    int exp_order [$];
    for (int i = 0; i < N; i++) m_stat_g[i] = 0;

    // Test 1: single read from channel 1.
    do_reset();
    check("reset_mem_read", LW'(mem_read), LW'(0));
    check("reset_ch_ready", LW'(ch_ready), LW'(0));
    fixed_data = 1; mem_lat = 3;
    ch_addr[1*AW +: AW] = 28'h0000123;
    ch_read = 2'b10;
    step();
    check("t1_mem_read", LW'(mem_read), LW'(1));
    check("t1_mem_addr", LW'(mem_addr), LW'(28'h0000123));
    wait_ready(20);
    check("t1_ch_ready", LW'(ch_ready), LW'(2'b10));
    check("t1_ch_rdata", ch_rdata, A5_LINE);
    step();
    check("t1_ready_pulse", LW'(ch_ready), LW'(0));
    fixed_data = 0;

    // Test 2: both channels continuously requesting alternate.
    do_reset();
    hold_mode = 1; mem_lat = 5;
    ch_read = 2'b11;
    wait_obs(4, 200);
    hold_mode = 0;
    ch_read = '0;
    run_until_quiet(40);
    exp_order = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++)
      check("t2_order", LW'(i < obs_q.size() ? obs_q[i] : -1), LW'(exp_order[i]));

    // Test 3: write on channel 0, then channel 1 waiting wins over channel 0's re-request.
    do_reset();
    mem_lat = 4;
    ch_write[0] = 1'b1;
    ch_wdata[0 +: LW] = T3_LINE;
    ch_addr[0 +: AW] = 28'h0ABCDEF;
    step();
    check("t3_mem_write", LW'(mem_write), LW'(1));
    check("t3_mem_wdata", mem_wdata, T3_LINE);
    ch_read[1] = 1'b1;
    wait_obs(1, 40);
    ch_read[0] = 1'b1;
    wait_obs(3, 80);
    run_until_quiet(40);
    exp_order = '{0, 1, 0};
    for (int i = 0; i < 3; i++)
      check("t3_order", LW'(i < obs_q.size() ? obs_q[i] : -1), LW'(exp_order[i]));

    // Test 4: reset while BUSY, then a stray mem_ready.
    do_reset();
    mem_lat = 10;
    ch_read[0] = 1'b1;
    step();
    step();
    step();
    check("t4_busy_mem_read", LW'(mem_read), LW'(1));
    proc_reset = 1'b1;
    ch_read = '0;
    step();
    proc_reset = 1'b0;
    check("t4_rst_mem_read", LW'(mem_read), LW'(0));
    check("t4_rst_ch_ready", LW'(ch_ready), LW'(0));
    mem_ready = 1'b1;
    mem_rdata = rnd_line();
    step();
    check("t4_spur_ready", LW'(ch_ready), LW'(0));
    step();
    check("t4_spur_ready2", LW'(ch_ready), LW'(0));

    // Test 5: read and write together on channel 1 is a write; idle mem_ready ignored.
    do_reset();
    mem_lat = 2;
    ch_read[1] = 1'b1;
    ch_write[1] = 1'b1;
    step();
    check("t5_mem_write", LW'(mem_write), LW'(1));
    check("t5_mem_read", LW'(mem_read), LW'(0));
    wait_ready(20);
    check("t5_ch_ready", LW'(ch_ready), LW'(2'b10));
    step();
    mem_ready = 1'b1;
    step();
    check("t5_idle_ready", LW'(ch_ready), LW'(0));
    step();
    check("t5_idle_ready2", LW'(ch_ready), LW'(0));

`ifdef MEMARB_STATS_EN
    // Test 6: three solo channel-0 grants, then two contended rounds.
    do_reset();
    mem_lat = 2;
    for (int r = 0; r < 3; r++) begin
      ch_read[0] = 1'b1;
      run_until_quiet(40);
    end
    check("t6_grants0_solo", LW'(stat_grants[15:0]), LW'(3));
    check("t6_conflicts_solo", LW'(stat_conflicts), LW'(0));
    for (int r = 0; r < 2; r++) begin
      ch_read = 2'b11;
      run_until_quiet(80);
    end
    check("t6_grants0", LW'(stat_grants[15:0]), LW'(5));
    check("t6_grants1", LW'(stat_grants[31:16]), LW'(2));
    check("t6_conflicts", LW'(stat_conflicts), LW'(2));
`endif

    // Randomized traffic: random ops, latencies, stray mem_ready and resets.
    do_reset();
    rand_en = 1; spur_en = 1; rand_lat = 1; rand_rst = 1;
    for (int c = 0; c < 4000; c++) step();
    rand_en = 0; spur_en = 0; rand_rst = 0;
    proc_reset = 1'b0;
    run_until_quiet(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
